qsys_irq_aggregator: RTL and testbench

QSYS_IRQ_AGGREGATOR -- requirements
Module: qsys_irq_aggregator

---
 rtl/qsys_irq_aggregator.sv | 117 +++++++++++
 tb/tb_qsys_irq_aggregator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/qsys_irq_aggregator.sv
// Avalon-MM interrupt aggregator: per-source edge/level pending, mask, priority
// readout and a saturating tick counter on source 0, combined into one registered irq_out.
module qsys_irq_aggregator #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq_out
);

  localparam int unsigned DW = 16;
  localparam int unsigned IW = 4;

  localparam logic [2:0] ADDR_PENDING  = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
  localparam logic [2:0] ADDR_RAW      = 3'd3;
  localparam logic [2:0] ADDR_HIGHEST  = 3'd4;
  localparam logic [2:0] ADDR_TICKS    = 3'd5;

  logic               wr_c;
  logic [NUM_SRC-1:0] wdata_c;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] edge_evt;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] edge_sel;
  logic [NUM_SRC-1:0] pending_nxt_c;
  logic [NUM_SRC-1:0] active_c;
  logic [DW-1:0]      ticks;
  logic [DW-1:0]      ticks_nxt_c;
  logic [DW-1:0]      rdata_c;
  logic [IW-1:0]      lowest_c;
  logic               unused_wdata;

  assign wr_c         = chipselect && !write_n;
  assign wdata_c      = writedata[NUM_SRC-1:0];
  assign active_c     = pending & mask;
  assign unused_wdata = ^writedata;

  // Synchroniser stage runs through reset so a line held high across release is not an edge.
  always_ff @(posedge clk) begin
    irq_q <= irq_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_evt <= '0;
      pending  <= '0;
      mask     <= '0;
      edge_sel <= '0;
      ticks    <= '0;
      readdata <= '0;
      irq_out  <= '0;
    end else begin
      edge_evt <= irq_in & ~irq_q;
      pending  <= pending_nxt_c;
      if (wr_c && (address == ADDR_MASK))     mask     <= wdata_c;
      if (wr_c && (address == ADDR_EDGE_SEL)) edge_sel <= wdata_c;
      ticks    <= ticks_nxt_c;
      readdata <= rdata_c;
      irq_out  <= |active_c;
    end
  end

  // Edge sources latch events (set beats W1C); level sources track the synchronised line.
  always_comb begin
    pending_nxt_c = pending;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (edge_sel[i]) begin
        if (edge_evt[i]) begin
          pending_nxt_c[i] = 1'b1;
        end else if (wr_c && (address == ADDR_PENDING) && wdata_c[i]) begin
          pending_nxt_c[i] = 1'b0;
        end
      end else begin
        pending_nxt_c[i] = irq_q[i];
      end
    end
  end

  always_comb begin
    ticks_nxt_c = ticks;
    if (wr_c && (address == ADDR_TICKS)) begin
      ticks_nxt_c = DW'(edge_evt[0]);
    end else if (edge_evt[0] && (ticks != '1)) begin
      ticks_nxt_c = ticks + DW'(1);
    end
  end

  always_comb begin
    lowest_c = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (active_c[i]) lowest_c = IW'(i);
    end
  end

  always_comb begin
    rdata_c = '0;
    case (address)
      ADDR_PENDING:  rdata_c = DW'(pending);
      ADDR_MASK:     rdata_c = DW'(mask);
      ADDR_EDGE_SEL: rdata_c = DW'(edge_sel);
      ADDR_RAW:      rdata_c = DW'(irq_q);
      ADDR_HIGHEST:  rdata_c = {|active_c, 11'd0, lowest_c};
      ADDR_TICKS:    rdata_c = ticks;
      default:       rdata_c = '0;
    endcase
  end

endmodule

// File: tb/tb_qsys_irq_aggregator.sv
// Directed bench for qsys_irq_aggregator: register map, edge/level pending,
// masking latency, tick saturation and reset behaviour.
module tb_qsys_irq_aggregator;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [7:0]  irq_in;
  logic        irq_out;

  int passed;
  int failed;
  int total;

  qsys_irq_aggregator #(.NUM_SRC(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq_out    (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk_rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
    address = a;
    tick(1);
    chk(tag, readdata, exp);
  endtask

  task automatic pulse0();
    irq_in[0] = 1'b1;
    tick(1);
    irq_in[0] = 1'b0;
    tick(1);
  endtask

  initial begin
    passed = 0; failed = 0; total = 0;
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 16'h0000; irq_in = 8'h00;
    tick(3);
    chk("rst_irq_out", 16'(irq_out), 16'h0000);
    chk("rst_readdata", readdata, 16'h0000);
    reset = 1'b0;
    for (int a = 0; a < 6; a++) chk_rd($sformatf("rst_reg%0d", a), 3'(a), 16'h0000);

    // Single-cycle pulse on edge source 0: pending one edge after capture, irq_out one later.
    wr(3'd1, 16'h0001);
    wr(3'd2, 16'h0001);
    address = 3'd0;
    irq_in = 8'h01;
    tick(1);
    irq_in = 8'h00;
    tick(1);
    chk("pulse_irq_out_early", 16'(irq_out), 16'h0000);
    tick(1);
    chk("pulse_irq_out", 16'(irq_out), 16'h0001);
    chk("pulse_pending", readdata, 16'h0001);
    chk_rd("pulse_ticks", 3'd5, 16'h0001);

    // W1C landing on the same edge as a new event: set wins.
    irq_in = 8'h01;
    tick(1);
    wr(3'd0, 16'h0001);
    irq_in = 8'h00;
    chk("setwin_irq_out_a", 16'(irq_out), 16'h0001);
    chk_rd("setwin_pending", 3'd0, 16'h0001);
    chk("setwin_irq_out_b", 16'(irq_out), 16'h0001);
    chk_rd("setwin_ticks", 3'd5, 16'h0002);
    wr(3'd0, 16'h0001);
    chk_rd("w1c_pending", 3'd0, 16'h0000);
    chk("w1c_irq_out", 16'(irq_out), 16'h0000);

    // Level sources, priority readout, mask latency.
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h0084);
    irq_in = 8'h84;
    tick(3);
    chk_rd("lvl_highest", 3'd4, 16'h8002);
    chk_rd("lvl_raw", 3'd3, 16'h0084);
    wr(3'd0, 16'h00FF);
    chk_rd("lvl_w1c_ignored", 3'd0, 16'h0084);
    wr(3'd1, 16'h0080);
    chk_rd("highest_idx7", 3'd4, 16'h8007);
    wr(3'd1, 16'h0000);
    chk("mask_off_irq_out_a", 16'(irq_out), 16'h0001);
    tick(1);
    chk("mask_off_irq_out_b", 16'(irq_out), 16'h0000);
    chk_rd("highest_none", 3'd4, 16'h0000);
    wr(3'd1, 16'hFF00);
    chk_rd("mask_upper_ignored", 3'd1, 16'h0000);
    wr(3'd6, 16'hFFFF);
    chk_rd("addr6_zero", 3'd6, 16'h0000);
    wr(3'd1, 16'h0084);
    irq_in = 8'h00;
    tick(2);
    chk("drop_irq_out_2", 16'(irq_out), 16'h0001);
    tick(1);
    chk("drop_irq_out_3", 16'(irq_out), 16'h0000);

    // Level-to-edge switch retains pending; edge-to-level switch follows the line again.
    irq_in = 8'h84;
    tick(3);
    wr(3'd2, 16'h0004);
    irq_in = 8'h00;
    tick(3);
    chk_rd("retain_pending", 3'd0, 16'h0004);
    wr(3'd2, 16'h0000);
    tick(1);
    chk_rd("follow_level", 3'd0, 16'h0000);

    // Tick counter saturation, clear, and clear coinciding with an event.
    @(negedge clk);
    force dut.ticks = 16'hFFFE;
    tick(1);
    release dut.ticks;
    pulse0();
    chk_rd("ticks_reach_max", 3'd5, 16'hFFFF);
    pulse0();
    pulse0();
    chk_rd("ticks_saturate", 3'd5, 16'hFFFF);
    wr(3'd5, 16'h1234);
    chk_rd("ticks_clear", 3'd5, 16'h0000);
    irq_in[0] = 1'b1;
    tick(1);
    wr(3'd5, 16'h0000);
    irq_in[0] = 1'b0;
    chk_rd("ticks_clear_with_rise", 3'd5, 16'h0001);

    // Line held high across reset release: no event. Level loads it first, so switch
    // to edge mode and clear, then confirm nothing re-sets it.
    irq_in = 8'h01;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    wr(3'd2, 16'h0001);
    wr(3'd0, 16'h0001);
    tick(2);
    chk_rd("held_pending", 3'd0, 16'h0000);
    chk_rd("held_ticks", 3'd5, 16'h0000);
    chk("held_irq_out", 16'(irq_out), 16'h0000);
    irq_in = 8'h00;

    // Reset mid-stream dominates a concurrent write and event.
    wr(3'd1, 16'h00FF);
    wr(3'd2, 16'h00FF);
    irq_in = 8'hFF;
    tick(1);
    irq_in = 8'h00;
    tick(2);
    chk_rd("pre_rst_pending", 3'd0, 16'h00FF);
    chk("pre_rst_irq_out", 16'(irq_out), 16'h0001);
    reset = 1'b1; address = 3'd1; writedata = 16'h000F;
    chipselect = 1'b1; write_n = 1'b0; irq_in = 8'hFF;
    tick(1);
    chk("midrst_irq_out", 16'(irq_out), 16'h0000);
    chk("midrst_readdata", readdata, 16'h0000);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1; irq_in = 8'h00;
    for (int a = 0; a < 6; a++) chk_rd($sformatf("post_rst_reg%0d", a), 3'(a), 16'h0000);
    chk("post_rst_irq_out", 16'(irq_out), 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
